sram_banked_ctrl: RTL

Parametrised, banked synchronous SRAM with a valid/ready request port, per-byte write enables, selectable read-first/write-first behaviour and an optional output register. After reset it runs a clear sequence that zeroes every word before accepting requests. Every accepted request, read or write, returns one response word. It is the digital successor to the single-bank 8x16 mixed-signal SRAM and sits between the core datapath and the analogue bit-cell model.

---
 rtl/sram_pkg.sv | 35 +++
 rtl/sram_banked_ctrl_bank.sv | 36 +++
 rtl/sram_banked_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state type and word helpers for the banked SRAM controller.
// Helpers work on a generous fixed width; callers cast operands and results to their own sizes.
package sram_pkg;

    localparam int MAX_DW = 256;
    localparam int MAX_NB = MAX_DW / 8;

    typedef enum logic {INIT, RUN} state_t;

    function automatic int bank_of(input int addr, input int nb);
        return addr % nb;
    endfunction

    function automatic int row_of(input int addr, input int nb);
        return addr / nb;
    endfunction

    function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                     input logic [MAX_DW-1:0] new_w,
                                                     input logic [MAX_NB-1:0] be);
        logic [MAX_DW-1:0] r;
        r = old_w;
        for (int i = 0; i < MAX_NB; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DW-1:0] d);
        logic [MAX_NB-1:0] p;
        for (int i = 0; i < MAX_NB; i++)
            p[i] = ^d[8*i +: 8];
        return p;
    endfunction

endpackage

// File: rtl/sram_banked_ctrl_bank.sv
// sram_bank: one bank's row array with byte-masked synchronous write and registered read of the old word.
// Words wider than DW carry one parity bit per byte above the data bits.
module sram_bank #(
    parameter int DW   = 32,
    parameter int SW   = 32,
    parameter int ROWS = 16,
    parameter int RW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic          re,
    input  logic [RW-1:0] row,
    input  logic [DW/8-1:0] be,
    input  logic [SW-1:0] wdata,
    output logic [SW-1:0] rdata
);

    logic [SW-1:0] mem [ROWS];
    logic [SW-1:0] mask;

    for (genvar i = 0; i < DW / 8; i++) begin : g_mask
        assign mask[8*i +: 8] = {8{be[i]}};
        if (SW > DW) begin : g_par
            assign mask[DW+i] = be[i];
        end
    end

    always_ff @(posedge clk)
        if (we) mem[row] <= (mem[row] & ~mask) | (wdata & mask);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[row];

endmodule

// File: rtl/sram_banked_ctrl.sv
// sram_banked_ctrl: banked SRAM with valid/ready requests, byte enables, clear-on-reset and optional output register.
// Define SRAM_PARITY_EN to store per-byte even parity and report it on rsp_perr.
module sram_banked_ctrl
    import sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_BANKS  = 4,
    parameter int READ_FIRST = 1,
    parameter int OUT_REG    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_perr,
    output logic                    init_done
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int ROWS = (2 ** ADDR_WIDTH) / NUM_BANKS;
    localparam int RW   = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int BW   = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
`ifdef SRAM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int SW = DATA_WIDTH + PAR * NB;

    state_t state, next_state;
    logic [RW-1:0] cnt;
    logic clearing, accept;
    logic [BW-1:0] bank_sel;
    logic [RW-1:0] row_sel;
    logic [SW-1:0] wword;
    logic [SW-1:0] bank_rdata [NUM_BANKS];

    logic s1_valid, s1_we;
    logic [NB-1:0] s1_be;
    logic [SW-1:0] s1_wword;
    logic [BW-1:0] s1_bank;
    logic [SW-1:0] old_word;
    logic [DATA_WIDTH-1:0] old_data, new_data, ret_data;
    logic ret_new, perr_c;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == INIT) cnt <= cnt + 1'b1;
        end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        if (state == INIT) next_state = (cnt == RW'(ROWS - 1)) ? RUN : INIT;
        else req_ready = 1'b1;
    end

    assign init_done = (state == RUN);
    assign clearing  = (state == INIT);
    assign accept    = req_valid & req_ready;
    assign bank_sel  = BW'(bank_of(int'(req_addr), NUM_BANKS));
    assign row_sel   = RW'(row_of(int'(req_addr), NUM_BANKS));

`ifdef SRAM_PARITY_EN
    // perr_inject is a force target for tests; an armed flip lands on the next write with any byte enabled.
    logic perr_inject, inject_armed;
    assign perr_inject = 1'b0;
    assign wword = {NB'(byte_parity(MAX_DW'(req_wdata))) ^ ((perr_inject | inject_armed) ? req_be : '0), req_wdata};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) inject_armed <= 1'b0;
        else if (accept && req_we && req_be != '0) inject_armed <= 1'b0;
        else if (perr_inject) inject_armed <= 1'b1;
`else
    assign wword = req_wdata;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sram_bank #(.DW(DATA_WIDTH), .SW(SW), .ROWS(ROWS), .RW(RW)) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (clearing | (accept & req_we & (bank_sel == BW'(b)))),
            .re    (accept & (bank_sel == BW'(b))),
            .row   (clearing ? cnt : row_sel),
            .be    (clearing ? {NB{1'b1}} : req_be),
            .wdata (clearing ? '0 : wword),
            .rdata (bank_rdata[b])
        );
    end

    // Stage fields only move on accept so the response word holds while idle.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_we    <= 1'b0;
            s1_be    <= '0;
            s1_wword <= '0;
            s1_bank  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_we    <= req_we;
                s1_be    <= req_be;
                s1_wword <= wword;
                s1_bank  <= bank_sel;
            end
        end

    assign old_word = bank_rdata[s1_bank];
    assign old_data = old_word[DATA_WIDTH-1:0];
    assign new_data = DATA_WIDTH'(byte_merge(MAX_DW'(old_data), MAX_DW'(s1_wword[DATA_WIDTH-1:0]), MAX_NB'(s1_be)));
    assign ret_new  = s1_we && (READ_FIRST == 0);
    assign ret_data = ret_new ? new_data : old_data;

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] old_par, new_par, ret_par;
    assign old_par = old_word[SW-1:DATA_WIDTH];
    assign new_par = (old_par & ~s1_be) | (s1_wword[SW-1:DATA_WIDTH] & s1_be);
    assign ret_par = ret_new ? new_par : old_par;
    assign perr_c  = s1_valid & (ret_par != NB'(byte_parity(MAX_DW'(ret_data))));
`else
    assign perr_c = 1'b0;
`endif

    if (OUT_REG != 0) begin : g_oreg
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
                rsp_perr  <= 1'b0;
            end else begin
                rsp_valid <= s1_valid;
                rsp_perr  <= perr_c;
                if (s1_valid) rsp_rdata <= ret_data;
            end
    end else begin : g_comb
        assign rsp_valid = s1_valid;
        assign rsp_rdata = ret_data;
        assign rsp_perr  = perr_c;
    end

endmodule
